// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SRV_IF = 2'd1,
    SRV_DM = 2'd2
  } state_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with zero flag; counts the memory access latency.
module lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero so an extra decrement never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between fetch and data
// requesters; data wins ties, one IDLE turnaround cycle between accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = 4,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  state_t state;
  state_t state_nxt;
  logic   cnt_zero_c;
  logic   dm_req_c;
  logic   if_req_c;
  logic   grant_dm_c;
  logic   grant_if_c;
  logic   finish_c;

  // A requester whose done is high this cycle is not regranted.
  assign dm_req_c = (dm_rd | dm_wr) & ~dm_done;
  assign if_req_c = if_req & ~if_done;

  assign if_stall = if_req & ~if_done;
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_req_c) begin
          state_nxt = SRV_DM;
        end else if (if_req_c) begin
          state_nxt = SRV_IF;
        end
      end
      SRV_IF, SRV_DM: begin
        if (cnt_zero_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_dm_c = 1'b0;
    grant_if_c = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        grant_dm_c = dm_req_c;
        grant_if_c = if_req_c & ~dm_req_c;
      end
      SRV_IF, SRV_DM: finish_c = cnt_zero_c;
      default: ;
    endcase
  end

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_dm_c | grant_if_c),
    .dec      (state != IDLE),
    .load_val (CNT_W'(LAT - 1)),
    .zero_c   (cnt_zero_c)
  );

  // Memory port latches, completion pulses and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err     <= dm_rd & dm_wr;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_dm_c) begin
        mem_en    <= 1'b1;
        mem_wr    <= dm_wr;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if_c) begin
        mem_en   <= 1'b1;
        mem_wr   <= 1'b0;
        mem_addr <= if_addr;
      end else if (finish_c) begin
        mem_en <= 1'b0;
        if (state == SRV_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          dm_done <= 1'b1;
          if (!mem_wr) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=4 instance and one LAT=1 instance,
// each with its own fixed-latency memory model.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned L0 = 4;
  localparam int unsigned L1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          if_req0 = 1'b0, dm_rd0 = 1'b0, dm_wr0 = 1'b0;
  logic [AW-1:0] if_addr0 = '0, dm_addr0 = '0;
  logic [DW-1:0] dm_wdata0 = '0;
  logic [DW-1:0] if_rdata0, dm_rdata0, mem_wdata0, mem_rdata0;
  logic [AW-1:0] mem_addr0;
  logic          if_done0, if_stall0, dm_done0, dm_stall0, mem_en0, mem_wr0, err0;

  logic          if_req1 = 1'b0, dm_rd1 = 1'b0, dm_wr1 = 1'b0;
  logic [AW-1:0] if_addr1 = '0, dm_addr1 = '0;
  logic [DW-1:0] dm_wdata1 = '0;
  logic [DW-1:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;
  logic          if_done1, if_stall1, dm_done1, dm_stall1, mem_en1, mem_wr1, err1;

  logic [DW-1:0] mem0 [65536];
  logic [DW-1:0] mem1 [65536];
  int wcnt0 = 0;
  int wcnt1 = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(L0), .AW(AW), .DW(DW)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0),
    .if_done(if_done0), .if_stall(if_stall0),
    .dm_rd(dm_rd0), .dm_wr(dm_wr0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0),
    .dm_rdata(dm_rdata0), .dm_done(dm_done0), .dm_stall(dm_stall0),
    .mem_en(mem_en0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .err(err0)
  );

  mem_arbiter #(.LAT(L1), .AW(AW), .DW(DW)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
    .if_done(if_done1), .if_stall(if_stall1),
    .dm_rd(dm_rd1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_stall(dm_stall1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .err(err1)
  );

  // Memory models: combinational read, write lands only after LAT full mem_en cycles.
  assign mem_rdata0 = mem0[mem_addr0];
  assign mem_rdata1 = mem1[mem_addr1];

  always @(posedge clk) begin
    if (mem_en0) begin
      if (mem_wr0 && (wcnt0 == int'(L0) - 1)) mem0[mem_addr0] <= mem_wdata0;
      wcnt0 <= wcnt0 + 1;
    end else begin
      wcnt0 <= 0;
    end
  end

  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_wr1 && (wcnt1 == int'(L1) - 1)) mem1[mem_addr1] <= mem_wdata1;
      wcnt1 <= wcnt1 + 1;
    end else begin
      wcnt1 <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[16'h0010] = 16'hA5C3;
    mem0[16'h0200] = 16'h1234;
    mem0[16'h0080] = 16'h5555;
    mem1[16'h0020] = 16'h7E57;

    step();
    step();
    rst = 1'b0;
    step();
    check("rst_mem_en", 32'(mem_en0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_if_done", 32'(if_done0), 32'd0);
    check("rst_dm_done", 32'(dm_done0), 32'd0);
    check("rst_if_rdata", 32'(if_rdata0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);

    // Fetch only
    if_req0 = 1'b1; if_addr0 = 16'h0010;
    #1;
    check("f_stall_c0", 32'(if_stall0), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("f_mem_en", 32'(mem_en0), 32'd1);
      check("f_mem_addr", 32'(mem_addr0), 32'h0010);
      check("f_mem_wr", 32'(mem_wr0), 32'd0);
      check("f_stall", 32'(if_stall0), 32'd1);
      check("f_done_early", 32'(if_done0), 32'd0);
    end
    step();
    check("f_done", 32'(if_done0), 32'd1);
    check("f_rdata", 32'(if_rdata0), 32'hA5C3);
    check("f_stall_c5", 32'(if_stall0), 32'd0);
    check("f_mem_en_c5", 32'(mem_en0), 32'd0);
    if_req0 = 1'b0;
    step();
    check("f_done_c6", 32'(if_done0), 32'd0);
    check("f_mem_en_c6", 32'(mem_en0), 32'd0);

    // Contention: data first, fetch right after
    if_req0 = 1'b1; if_addr0 = 16'h0010;
    dm_rd0 = 1'b1; dm_addr0 = 16'h0200;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("c_dm_addr", 32'(mem_addr0), 32'h0200);
      check("c_mem_en", 32'(mem_en0), 32'd1);
      check("c_if_stall", 32'(if_stall0), 32'd1);
      check("c_dm_stall", 32'(dm_stall0), 32'd1);
    end
    step();
    check("c_dm_done", 32'(dm_done0), 32'd1);
    check("c_dm_rdata", 32'(dm_rdata0), 32'h1234);
    check("c_if_stall_c5", 32'(if_stall0), 32'd1);
    check("c_mem_en_c5", 32'(mem_en0), 32'd0);
    dm_rd0 = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      step();
      check("c_if_mem_en", 32'(mem_en0), 32'd1);
      check("c_if_mem_addr", 32'(mem_addr0), 32'h0010);
      check("c_if_stall_wait", 32'(if_stall0), 32'd1);
      check("c_dm_done_once", 32'(dm_done0), 32'd0);
    end
    step();
    check("c_if_done", 32'(if_done0), 32'd1);
    check("c_if_rdata", 32'(if_rdata0), 32'hA5C3);
    if_req0 = 1'b0;
    step();

    // Write with data changed mid-service; request held through done cycle
    dm_wr0 = 1'b1; dm_addr0 = 16'h0040; dm_wdata0 = 16'hBEEF;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) dm_wdata0 = 16'h0000;
      check("w_mem_en", 32'(mem_en0), 32'd1);
      check("w_mem_wr", 32'(mem_wr0), 32'd1);
      check("w_mem_wdata", 32'(mem_wdata0), 32'hBEEF);
      check("w_mem_addr", 32'(mem_addr0), 32'h0040);
    end
    step();
    check("w_dm_done", 32'(dm_done0), 32'd1);
    check("w_dm_rdata_kept", 32'(dm_rdata0), 32'h1234);
    step();
    check("w_no_regrant", 32'(mem_en0), 32'd0);
    dm_wr0 = 1'b0;
    check("w_mem_written", 32'(mem0[16'h0040]), 32'hBEEF);
    step();
    check("w_idle", 32'(mem_en0), 32'd0);

    // No double grant on a held read
    dm_rd0 = 1'b1; dm_addr0 = 16'h0010;
    for (int k = 1; k <= 4; k++) step();
    step();
    check("n_dm_done", 32'(dm_done0), 32'd1);
    check("n_dm_rdata", 32'(dm_rdata0), 32'hA5C3);
    step();
    check("n_mem_en_c6", 32'(mem_en0), 32'd0);
    check("n_dm_done_c6", 32'(dm_done0), 32'd0);
    dm_rd0 = 1'b0;
    step();
    check("n_mem_en_c7", 32'(mem_en0), 32'd0);

    // Reset in the 2nd cycle of a write
    dm_wr0 = 1'b1; dm_addr0 = 16'h0080; dm_wdata0 = 16'h1111;
    step();
    check("r_mem_en_c1", 32'(mem_en0), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; dm_wr0 = 1'b0;
    check("r_mem_en", 32'(mem_en0), 32'd0);
    check("r_mem_wr", 32'(mem_wr0), 32'd0);
    check("r_dm_done", 32'(dm_done0), 32'd0);
    step();
    check("r_mem_en_c4", 32'(mem_en0), 32'd0);
    check("r_dm_done_c4", 32'(dm_done0), 32'd0);
    check("r_unwritten", 32'(mem0[16'h0080]), 32'h5555);
    step();

    // Illegal rd+wr: err for one cycle, performed as a write
    dm_rd0 = 1'b1; dm_wr0 = 1'b1; dm_addr0 = 16'h0050; dm_wdata0 = 16'hCAFE;
    step();
    check("e_err", 32'(err0), 32'd1);
    check("e_mem_wr", 32'(mem_wr0), 32'd1);
    check("e_mem_en", 32'(mem_en0), 32'd1);
    dm_rd0 = 1'b0;
    step();
    check("e_err_c2", 32'(err0), 32'd0);
    for (int k = 3; k <= 5; k++) step();
    check("e_dm_done", 32'(dm_done0), 32'd1);
    dm_wr0 = 1'b0;
    step();
    check("e_written", 32'(mem0[16'h0050]), 32'hCAFE);
    check("e_err_end", 32'(err0), 32'd0);

    // LAT=1 fetch
    if_req1 = 1'b1; if_addr1 = 16'h0020;
    step();
    check("l1_mem_en", 32'(mem_en1), 32'd1);
    check("l1_done_c1", 32'(if_done1), 32'd0);
    check("l1_stall_c1", 32'(if_stall1), 32'd1);
    step();
    check("l1_mem_en_c2", 32'(mem_en1), 32'd0);
    check("l1_done", 32'(if_done1), 32'd1);
    check("l1_rdata", 32'(if_rdata1), 32'h7E57);
    if_req1 = 1'b0;
    step();
    check("l1_done_c3", 32'(if_done1), 32'd0);
    check("l1_mem_en_c3", 32'(mem_en1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
